// File: rtl/key_event_if.sv
// Bundles the debounced button inputs and the decoded-event handshake.
// master: the decoder; slave: whatever drives the button and consumes events.
interface key_event_if;
  logic       btn_level;
  logic       btn_press;
  logic       btn_release;
  logic       event_valid;
  logic [1:0] event_code;
  logic       event_ready;
  logic       event_overflow;
  logic       busy;

  modport master (
    input  btn_level, btn_press, btn_release, event_ready,
    output event_valid, event_code, event_overflow, busy
  );

  modport slave (
    output btn_level, btn_press, btn_release, event_ready,
    input  event_valid, event_code, event_overflow, busy
  );
endinterface

// File: rtl/key_event_decoder.sv
// Classifies debounced key activity into SHORT/LONG/DOUBLE events behind a one-entry valid/ready buffer.
// Define KEY_AUTO_REPEAT_EN to emit REPEAT events every REPEAT_MS while a long press is held.
module key_event_decoder #(
  parameter int unsigned N         = 32,
  parameter int unsigned FREQ      = 50,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned DCLICK_MS = 300,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic         clk,
  input  logic         rst,
  key_event_if.master  bus
);

  localparam longint unsigned CNT_MAX     = (N >= 64) ? {64{1'b1}} : ((64'd1 << N) - 64'd1);
  localparam longint unsigned LONG_CNT_W   = 64'(LONG_MS)   * 64'd1000 * 64'(FREQ);
  localparam longint unsigned DCLICK_CNT_W = 64'(DCLICK_MS) * 64'd1000 * 64'(FREQ);
  localparam longint unsigned REPEAT_CNT_W = 64'(REPEAT_MS) * 64'd1000 * 64'(FREQ);

  // Every timing constant must be representable in the N-bit timer.
  if (N == 0 || LONG_CNT_W > CNT_MAX || DCLICK_CNT_W > CNT_MAX || REPEAT_CNT_W > CNT_MAX) begin : g_cnt_range_err
    $error("key_event_decoder: timing constant does not fit in N bits");
  end

  localparam logic [N-1:0] LONG_LAST   = N'(LONG_CNT_W - 64'd1);
  localparam logic [N-1:0] DCLICK_LAST = N'(DCLICK_CNT_W - 64'd1);
  localparam logic [N-1:0] TIMER_MAX   = {N{1'b1}};
`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [N-1:0] REPEAT_LAST = N'(REPEAT_CNT_W - 64'd1);
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    PRESS2    = 3'd3,
    LONG_HOLD = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CODE_REPEAT = 2'b00,
    CODE_SHORT  = 2'b01,
    CODE_LONG   = 2'b10,
    CODE_DOUBLE = 2'b11
  } code_e;

  state_e       state_q, state_d;
  logic [N-1:0] timer_q, timer_d;
  logic [N-1:0] stuck_q, stuck_d;
  logic         valid_q, valid_d;
  code_e        code_q,  code_d;
  logic         ovf_q,   ovf_d;
  logic         busy_q,  busy_d;

  logic         press;
  logic         release_edge;
  logic         stuck_cond;
  logic         stuck_hit;
  logic         new_evt;
  code_e        new_code;
  logic         timer_restart;

  // Simultaneous press and release pulses cancel each other.
  assign press        = bus.btn_press & ~bus.btn_release;
  assign release_edge = bus.btn_release & ~bus.btn_press;

  // Level high while a key should be down means an edge was lost; WAIT2 legitimately sees it high.
  assign stuck_cond = bus.btn_level && (state_q != IDLE) && (state_q != WAIT2);
  assign stuck_hit  = stuck_cond && (stuck_q == DCLICK_LAST);

  // Next-state and event decision.
  always_comb begin
    state_d       = state_q;
    new_evt       = 1'b0;
    new_code      = CODE_SHORT;
    timer_restart = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press) state_d = PRESS1;
      end
      PRESS1: begin
        if (release_edge) begin
          state_d = WAIT2;
        end else if (stuck_hit) begin
          state_d = IDLE;
        end else if (timer_q == LONG_LAST) begin
          state_d  = LONG_HOLD;
          new_evt  = 1'b1;
          new_code = CODE_LONG;
        end
      end
      WAIT2: begin
        if (press) begin
          state_d = PRESS2;
        end else if (timer_q == DCLICK_LAST) begin
          state_d  = IDLE;
          new_evt  = 1'b1;
          new_code = CODE_SHORT;
        end
      end
      PRESS2: begin
        if (release_edge) begin
          state_d  = IDLE;
          new_evt  = 1'b1;
          new_code = CODE_DOUBLE;
        end else if (stuck_hit) begin
          state_d = IDLE;
        end
      end
      LONG_HOLD: begin
        if (release_edge) begin
          state_d = IDLE;
        end else if (stuck_hit) begin
          state_d = IDLE;
        end
`ifdef KEY_AUTO_REPEAT_EN
        else if (timer_q == REPEAT_LAST) begin
          new_evt       = 1'b1;
          new_code      = CODE_REPEAT;
          timer_restart = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Saturating phase timer and lost-edge watchdog.
  always_comb begin
    timer_d = timer_q;
    stuck_d = stuck_q;
    if (state_d != state_q || timer_restart) begin
      timer_d = '0;
    end else if (timer_q != TIMER_MAX) begin
      timer_d = timer_q + N'(1);
    end
    if (state_d != state_q || !stuck_cond) begin
      stuck_d = '0;
    end else if (stuck_q != TIMER_MAX) begin
      stuck_d = stuck_q + N'(1);
    end
  end

  // Single-entry event buffer; a held event is never overwritten.
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    ovf_d   = 1'b0;
    busy_d  = (state_d != IDLE);
    if (valid_q && bus.event_ready) begin
      valid_d = new_evt;
      if (new_evt) code_d = new_code;
    end else if (valid_q) begin
      ovf_d = new_evt;
    end else if (new_evt) begin
      valid_d = 1'b1;
      code_d  = new_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      stuck_q <= '0;
      valid_q <= 1'b0;
      code_q  <= CODE_REPEAT;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      stuck_q <= stuck_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.event_valid    = valid_q;
  assign bus.event_code     = code_q;
  assign bus.event_overflow = ovf_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder: directed scenarios plus random gestures vs. a timeline model.
// Honours KEY_AUTO_REPEAT_EN the same way the design does.
module tb_key_event_decoder;

  localparam int unsigned T_FREQ      = 1;
  localparam int unsigned T_LONG_MS   = 2;
  localparam int unsigned T_DCLICK_MS = 1;
  localparam int unsigned T_REPEAT_MS = 1;
  localparam int unsigned LONG_CNT    = T_LONG_MS   * 1000 * T_FREQ;
  localparam int unsigned DCLICK_CNT  = T_DCLICK_MS * 1000 * T_FREQ;
  localparam int unsigned REPEAT_CNT  = T_REPEAT_MS * 1000 * T_FREQ;

  typedef struct {
    int unsigned t;
    logic [1:0]  c;
  } evt_t;

  logic clk = 1'b0;
  logic rst;

  key_event_if bus ();

  key_event_decoder #(
    .N         (32),
    .FREQ      (T_FREQ),
    .LONG_MS   (T_LONG_MS),
    .DCLICK_MS (T_DCLICK_MS),
    .REPEAT_MS (T_REPEAT_MS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned edge_n    = 0;
  int unsigned valid_cnt = 0;
  int          checks    = 0;
  int          fails     = 0;
  evt_t        obs_q[$];
  evt_t        exp_q[$];

  always @(posedge clk) edge_n <= edge_n + 1;

  // Every cycle with event_valid high is logged with the edge that produced it.
  always @(negedge clk) begin
    if (bus.event_valid === 1'b1) begin
      obs_q.push_back('{t: edge_n, c: bus.event_code});
      valid_cnt <= valid_cnt + 1;
    end
  end

  task automatic cycles(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_press();
    bus.btn_press = 1'b1;
    bus.btn_level = 1'b0;
    cycles(1);
    bus.btn_press = 1'b0;
  endtask

  task automatic drive_release();
    bus.btn_release = 1'b1;
    bus.btn_level   = 1'b1;
    cycles(1);
    bus.btn_release = 1'b0;
  endtask

  // Press on the next edge, release exactly h edges later.
  task automatic play_press(input int unsigned h);
    drive_press();
    cycles(h - 1);
    drive_release();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycles(2);
    checks++; if (bus.event_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", bus.event_valid); end
    checks++; if (bus.event_code !== 2'b00) begin fails++; $display("FAIL reset_code: got %0b want 00", bus.event_code); end
    checks++; if (bus.event_overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %0b want 0", bus.event_overflow); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    rst = 1'b0;
    cycles(2);
  endtask

  task automatic test_short();
    int unsigned c0;
    c0 = valid_cnt;
    play_press(500);
    cycles(DCLICK_CNT - 1);
    checks++; if (bus.event_valid !== 1'b0) begin fails++; $display("FAIL short_early: got valid %0b want 0", bus.event_valid); end
    cycles(1);
    checks++; if (bus.event_valid !== 1'b1 || bus.event_code !== 2'b01) begin fails++; $display("FAIL short_event: got v%0b c%0b want v1 c01", bus.event_valid, bus.event_code); end
    cycles(2);
    checks++; if (valid_cnt !== c0 + 1) begin fails++; $display("FAIL short_count: got %0d valid cycles want 1", valid_cnt - c0); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL short_busy: got %0b want 0", bus.busy); end
  endtask

  task automatic test_long();
    int unsigned c0;
    c0 = valid_cnt;
    drive_press();
    cycles(LONG_CNT - 1);
    checks++; if (bus.event_valid !== 1'b0 || bus.busy !== 1'b1) begin fails++; $display("FAIL long_early: got v%0b busy%0b want v0 busy1", bus.event_valid, bus.busy); end
    cycles(1);
    checks++; if (bus.event_valid !== 1'b1 || bus.event_code !== 2'b10) begin fails++; $display("FAIL long_event: got v%0b c%0b want v1 c10", bus.event_valid, bus.event_code); end
    cycles(REPEAT_CNT);
`ifdef KEY_AUTO_REPEAT_EN
    checks++; if (bus.event_valid !== 1'b1 || bus.event_code !== 2'b00) begin fails++; $display("FAIL long_repeat: got v%0b c%0b want v1 c00", bus.event_valid, bus.event_code); end
`else
    checks++; if (bus.event_valid !== 1'b0) begin fails++; $display("FAIL long_norepeat: got v%0b want v0", bus.event_valid); end
`endif
    cycles(499);
    drive_release();
    cycles(1500);
`ifdef KEY_AUTO_REPEAT_EN
    checks++; if (valid_cnt !== c0 + 2) begin fails++; $display("FAIL long_count: got %0d events want 2", valid_cnt - c0); end
`else
    checks++; if (valid_cnt !== c0 + 1) begin fails++; $display("FAIL long_count: got %0d events want 1", valid_cnt - c0); end
`endif
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL long_busy: got %0b want 0", bus.busy); end
  endtask

  task automatic test_double();
    int unsigned c0;
    c0 = valid_cnt;
    play_press(300);
    cycles(399);
    play_press(300);
    checks++; if (bus.event_valid !== 1'b1 || bus.event_code !== 2'b11) begin fails++; $display("FAIL double_event: got v%0b c%0b want v1 c11", bus.event_valid, bus.event_code); end
    checks++; if (valid_cnt !== c0) begin fails++; $display("FAIL double_before: got %0d early events want 0", valid_cnt - c0); end
    cycles(1200);
    checks++; if (valid_cnt !== c0 + 1) begin fails++; $display("FAIL double_count: got %0d events want 1", valid_cnt - c0); end
  endtask

  task automatic test_boundary();
    int unsigned c0;
    c0 = valid_cnt;
    play_press(LONG_CNT);
    cycles(DCLICK_CNT);
    checks++; if (valid_cnt !== c0) begin fails++; $display("FAIL bnd_nolong: got %0d events want 0", valid_cnt - c0); end
    checks++; if (bus.event_valid !== 1'b1 || bus.event_code !== 2'b01) begin fails++; $display("FAIL bnd_short: got v%0b c%0b want v1 c01", bus.event_valid, bus.event_code); end
    cycles(5);
    c0 = valid_cnt;
    play_press(200);
    cycles(DCLICK_CNT - 1);
    play_press(100);
    checks++; if (valid_cnt !== c0) begin fails++; $display("FAIL bnd_noshort: got %0d events want 0", valid_cnt - c0); end
    checks++; if (bus.event_valid !== 1'b1 || bus.event_code !== 2'b11) begin fails++; $display("FAIL bnd_double: got v%0b c%0b want v1 c11", bus.event_valid, bus.event_code); end
    cycles(5);
  endtask

  task automatic test_backpressure();
    bus.event_ready = 1'b0;
    play_press(100);
    cycles(DCLICK_CNT);
    checks++; if (bus.event_valid !== 1'b1 || bus.event_code !== 2'b01) begin fails++; $display("FAIL bp_short: got v%0b c%0b want v1 c01", bus.event_valid, bus.event_code); end
    cycles(5);
    drive_press();
    cycles(LONG_CNT - 1);
    checks++; if (bus.event_overflow !== 1'b0) begin fails++; $display("FAIL bp_ovf_early: got %0b want 0", bus.event_overflow); end
    cycles(1);
    checks++; if (bus.event_overflow !== 1'b1 || bus.event_code !== 2'b01) begin fails++; $display("FAIL bp_ovf: got ovf%0b c%0b want ovf1 c01", bus.event_overflow, bus.event_code); end
    cycles(1);
    checks++; if (bus.event_overflow !== 1'b0 || bus.event_valid !== 1'b1 || bus.event_code !== 2'b01) begin fails++; $display("FAIL bp_hold: got ovf%0b v%0b c%0b want ovf0 v1 c01", bus.event_overflow, bus.event_valid, bus.event_code); end
    bus.event_ready = 1'b1;
    cycles(1);
    checks++; if (bus.event_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: got v%0b want 0", bus.event_valid); end
    cycles(200);
    drive_release();
    cycles(2);
    checks++; if (bus.busy !== 1'b0 || bus.event_valid !== 1'b0) begin fails++; $display("FAIL bp_idle: got busy%0b v%0b want 0 0", bus.busy, bus.event_valid); end
  endtask

  task automatic test_reset_mid_hold();
    int unsigned c0;
    drive_press();
    cycles(1000);
    rst = 1'b1;
    #1;
    checks++; if ({bus.event_valid, bus.event_code, bus.event_overflow, bus.busy} !== 5'b0) begin fails++; $display("FAIL rst_hold_outputs: got v%0b c%0b o%0b b%0b want all 0", bus.event_valid, bus.event_code, bus.event_overflow, bus.busy); end
    cycles(3);
    rst = 1'b0;
    c0 = valid_cnt;
    cycles(50);
    drive_release();
    cycles(2500);
    checks++; if (valid_cnt !== c0 || bus.busy !== 1'b0) begin fails++; $display("FAIL rst_hold_after: got %0d events busy%0b want 0 0", valid_cnt - c0, bus.busy); end
  endtask

  task automatic test_lost_edge();
    int unsigned c0;
    c0 = valid_cnt;
    bus.btn_press = 1'b1;
    cycles(1);
    bus.btn_press = 1'b0;
    cycles(DCLICK_CNT - 1);
    checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL lost_busy: got %0b want 1", bus.busy); end
    cycles(1);
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL lost_idle: got %0b want 0", bus.busy); end
    cycles(2);
    checks++; if (valid_cnt !== c0) begin fails++; $display("FAIL lost_noevent: got %0d events want 0", valid_cnt - c0); end
  endtask

  // Random gestures; expected events come from edge timestamps and the classification thresholds.
  task automatic test_random();
    int unsigned sel, h, h2, g, t, r;
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      sel = $urandom_range(0, 4);
      case (i % 3)
        0: begin
          h = (sel == 0) ? 1 : (sel == 1) ? LONG_CNT - 1 : (sel == 2) ? LONG_CNT : $urandom_range(1, LONG_CNT);
          t = edge_n + 1;
          play_press(h);
          exp_q.push_back('{t: t + h + DCLICK_CNT, c: 2'b01});
          cycles(DCLICK_CNT + $urandom_range(0, 30));
        end
        1: begin
          h  = $urandom_range(1, LONG_CNT);
          g  = (sel == 0) ? 1 : (sel == 1) ? DCLICK_CNT - 1 : (sel == 2) ? DCLICK_CNT : $urandom_range(1, DCLICK_CNT);
          h2 = $urandom_range(1, 1500);
          play_press(h);
          cycles(g - 1);
          play_press(h2);
          r = edge_n;
          exp_q.push_back('{t: r, c: 2'b11});
          cycles($urandom_range(0, 30));
        end
        default: begin
          h = (sel == 0) ? LONG_CNT + 1 : (sel == 1) ? LONG_CNT + REPEAT_CNT : (sel == 2) ? LONG_CNT + REPEAT_CNT + 1 : $urandom_range(LONG_CNT + 1, 3700);
          t = edge_n + 1;
          play_press(h);
          exp_q.push_back('{t: t + LONG_CNT, c: 2'b10});
`ifdef KEY_AUTO_REPEAT_EN
          for (int unsigned k = 1; LONG_CNT + k * REPEAT_CNT < h; k++)
            exp_q.push_back('{t: t + LONG_CNT + k * REPEAT_CNT, c: 2'b00});
`endif
          cycles($urandom_range(0, 30));
        end
      endcase
    end
    cycles(DCLICK_CNT + 500);
    checks++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL rand_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].t !== exp_q[i].t || obs_q[i].c !== exp_q[i].c) begin
        fails++;
        $display("FAIL rand_event[%0d]: got edge %0d code %0b want edge %0d code %0b", i, obs_q[i].t, obs_q[i].c, exp_q[i].t, exp_q[i].c);
      end
    end
  endtask

  initial begin
    bus.btn_level   = 1'b1;
    bus.btn_press   = 1'b0;
    bus.btn_release = 1'b0;
    bus.event_ready = 1'b1;
    rst             = 1'b1;
    test_reset();
    test_short();
    test_long();
    test_double();
    test_boundary();
    test_backpressure();
    test_reset_mid_hold();
    test_lost_edge();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
